fde_sequencer: RTL and testbench
================================

Name: fde_sequencer

Overview:
- Fetch-decode-execute sequencer for the 16-bit processor, instantiated inside the control unit and clocked by the control unit's generated clock.
- Steps through instruction phases and publishes the current phase as a 2-bit state code.
- Also provides per-phase strobes, an instruction-complete pulse and a retired-instruction counter to the rest of the control path.

Parameters:
- EXEC_CYCLES, 1, number of clock cycles spent in EXECUTE. Legal range 1..16.
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- en  input  1  advance enable; 0 freezes all state.
- state  output  2  current phase: 00 FETCH, 01 DECODE, 10 EXECUTE, 11 WRITEBACK.
- fetch_stb  output  1  high while in FETCH and en=1.
- decode_stb  output  1  high while in DECODE and en=1.
- exec_stb  output  1  high while in EXECUTE and en=1.
- wb_stb  output  1  high while in WRITEBACK and en=1.
- instr_done  output  1  one-cycle pulse on the last cycle of an instruction.
- instr_count  output  COUNT_W  number of retired instructions, wraps modulo 2^COUNT_W.

Behaviour:
- All registers update only on the rising edge of clk. Strobes and instr_done are combinational from the registered state, the execute counter and en.
- Reset (reset=0 at a rising edge):
  - state=00 (FETCH), execute counter=0, instr_count=0.
  - Reset has priority over en and applies even mid-EXECUTE.
  - While reset is low, all strobes and instr_done are 0.
- Hold: with reset=1 and en=0, state, execute counter and instr_count hold their values, and all strobes and instr_done read 0.
- Transitions (reset=1, en=1):
  - FETCH -> DECODE.
  - DECODE -> EXECUTE; the execute counter loads 0.
  - EXECUTE stays in EXECUTE, incrementing the execute counter, until the counter equals EXEC_CYCLES-1.
  - On that last execute cycle, EXECUTE -> FETCH, or EXECUTE -> WRITEBACK when FDE_WRITEBACK_EN is defined.
  - WRITEBACK -> FETCH.
- Latency:
  - One instruction takes 2+EXEC_CYCLES enabled cycles, or 3+EXEC_CYCLES with writeback.
  - Cycles with en=0 do not count toward latency.
- instr_done:
  - High in the final enabled cycle of an instruction: the last EXECUTE cycle without writeback, or the WRITEBACK cycle with it.
  - instr_count increments by 1 on the same clock edge that leaves that cycle.
- instr_count wraps from all-ones to 0 without any flag.
- Illegal or unreachable encodings:
  - Without writeback, code 11 is unreachable. If it occurs anyway, the next enabled edge goes to FETCH with no count increment and no instr_done.
  - An execute counter at or above EXEC_CYCLES is treated as the last cycle.
- en toggling mid-EXECUTE pauses the execute counter exactly; no cycle is lost or repeated.
- The state output is a direct register output, with no glitches between edges.

Optional Feature:
- Macro FDE_WRITEBACK_EN.
- Defined:
  - WRITEBACK phase (state=11, wb_stb) is inserted after EXECUTE.
  - instr_done fires in WRITEBACK.
- Undefined:
  - EXECUTE returns directly to FETCH and instr_done fires on the last EXECUTE cycle.
  - wb_stb is tied to 0 and code 11 is never produced.

Test Plan:
- Reset then run: hold reset=0 for 2 edges, then reset=1, en=1, EXEC_CYCLES=1, macro undefined -> state sequence 00,01,10,00,01,10; instr_done high in each 10 cycle; instr_count=2 after 6 edges.
- Freeze: en=0 for 3 edges while in DECODE -> state stays 01, decode_stb=0, instr_count unchanged; en=1 -> next edge gives state 10.
- Multi-cycle execute: EXEC_CYCLES=3 -> state 10 for exactly 3 enabled cycles; en dropped for 2 cycles mid-execute still yields 3 enabled execute cycles; instr_done only on the third.
- Writeback: FDE_WRITEBACK_EN defined, EXEC_CYCLES=1 -> sequence 00,01,10,11,00; wb_stb high in 11; instr_count increments after 11, not after 10.
- Reset mid-operation: assert reset=0 while in EXECUTE with instr_count=5 -> next edge gives state=00 and instr_count=0 regardless of en.
- Wrap: COUNT_W=4, run 16 instructions -> instr_count returns to 0.

Source files
------------

// File: rtl/fde_sequencer.sv
// -----------------------------------------------------------------------------
// fde_sequencer
//
// Fetch-decode-execute phase sequencer for the 16-bit processor control unit.
// Walks FETCH -> DECODE -> EXECUTE (EXEC_CYCLES cycles) [-> WRITEBACK] and
// publishes the current phase, per-phase strobes, an instruction-complete
// pulse and a retired-instruction counter.
//
// Build option:
//   FDE_WRITEBACK_EN  when defined, a WRITEBACK phase (code 11) follows
//                     EXECUTE and instr_done fires in WRITEBACK. When
//                     undefined, EXECUTE returns straight to FETCH, instr_done
//                     fires on the last EXECUTE cycle and wb_stb is tied to 0.
//
// Parameters:
//   EXEC_CYCLES  cycles spent in EXECUTE, legal range 1..16
//   COUNT_W      width of the retired-instruction counter
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   en           advance enable; 0 freezes all state
//   state        current phase (00 FETCH, 01 DECODE, 10 EXECUTE, 11 WRITEBACK),
//                driven straight from the state register
//   fetch_stb    FETCH  and en
//   decode_stb   DECODE and en
//   exec_stb     EXECUTE and en
//   wb_stb       WRITEBACK and en (0 without FDE_WRITEBACK_EN)
//   instr_done   high in the final enabled cycle of an instruction
//   instr_count  retired instructions, wraps modulo 2^COUNT_W
//
// Enable semantics: en is a plain advance qualifier, not a handshake. A cycle
// in which reset=1 and en=1 is one enabled cycle: its strobe is high and the
// following rising edge moves the sequence on by exactly one step. Any cycle
// with en=0 (or reset=0) shows no strobes and does not advance.
// -----------------------------------------------------------------------------
module fde_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [1:0]         state,
    output logic               fetch_stb,
    output logic               decode_stb,
    output logic               exec_stb,
    output logic               wb_stb,
    output logic               instr_done,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_WB     = 2'b11
    } phase_e;

    // Counter value that marks the final EXECUTE cycle. Compared with >= so a
    // counter that somehow sits above it still ends the phase.
    localparam logic [4:0] LAST_CNT = 5'(EXEC_CYCLES - 1);

    phase_e               state_q, state_d;
    logic [3:0]           exec_cnt_q, exec_cnt_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 exec_last;
    logic                 advance;

    assign advance   = reset & en;
    assign exec_last = ({1'b0, exec_cnt_q} >= LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            exec_cnt_q <= 4'd0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exec_cnt_d = exec_cnt_q;
        count_d    = count_q;
        fetch_stb  = 1'b0;
        decode_stb = 1'b0;
        exec_stb   = 1'b0;
        wb_stb     = 1'b0;
        instr_done = 1'b0;

        if (advance) begin
            case (state_q)
                S_FETCH: begin
                    fetch_stb = 1'b1;
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    decode_stb = 1'b1;
                    state_d    = S_EXEC;
                    exec_cnt_d = 4'd0;
                end
                S_EXEC: begin
                    exec_stb = 1'b1;
                    if (exec_last) begin
`ifdef FDE_WRITEBACK_EN
                        state_d = S_WB;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                        count_d    = count_q + COUNT_W'(1);
`endif
                    end else begin
                        exec_cnt_d = exec_cnt_q + 4'd1;
                    end
                end
                S_WB: begin
`ifdef FDE_WRITEBACK_EN
                    wb_stb     = 1'b1;
                    instr_done = 1'b1;
                    count_d    = count_q + COUNT_W'(1);
`endif
                    // Without writeback this code is unreachable; recover to
                    // FETCH silently, retiring nothing.
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fde_sequencer
//
// Three sequencer instances share clk/reset/en:
//   inst0: EXEC_CYCLES=1,  COUNT_W=16
//   inst1: EXEC_CYCLES=3,  COUNT_W=4
//   inst2: EXEC_CYCLES=16, COUNT_W=8
// The reference model tracks, per instance, only the position inside the
// current instruction (0 .. length-1, counted in enabled cycles) and the number
// of retired instructions; phase, strobes and instr_done are derived from that
// position.
// -----------------------------------------------------------------------------
module tb_fde_sequencer;

    localparam int N = 3;
`ifdef FDE_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    int ecyc [N] = '{1, 3, 16};
    int cw   [N] = '{16, 4, 8};

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic en    = 1'b0;

    logic [1:0] st [N];
    logic       fs [N];
    logic       ds [N];
    logic       es [N];
    logic       ws [N];
    logic       dn [N];
    logic [15:0] c0;
    logic [3:0]  c1;
    logic [7:0]  c2;

    fde_sequencer #(.EXEC_CYCLES(1), .COUNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .state(st[0]),
        .fetch_stb(fs[0]), .decode_stb(ds[0]), .exec_stb(es[0]), .wb_stb(ws[0]),
        .instr_done(dn[0]), .instr_count(c0)
    );
    fde_sequencer #(.EXEC_CYCLES(3), .COUNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .state(st[1]),
        .fetch_stb(fs[1]), .decode_stb(ds[1]), .exec_stb(es[1]), .wb_stb(ws[1]),
        .instr_done(dn[1]), .instr_count(c1)
    );
    fde_sequencer #(.EXEC_CYCLES(16), .COUNT_W(8)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .state(st[2]),
        .fetch_stb(fs[2]), .decode_stb(ds[2]), .exec_stb(es[2]), .wb_stb(ws[2]),
        .instr_done(dn[2]), .instr_count(c2)
    );

    // ------------------------------------------------------------ scoreboard
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    int pos  [N];
    int mcnt [N];
    bit model_valid = 1'b0;
    int exec_seen = 0;
    int done_seen = 0;

    function automatic int ilen(input int i);
        return 2 + ecyc[i] + WB;
    endfunction

    // 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK from position in instruction
    function automatic int exp_phase(input int i);
        if (pos[i] == 0) return 0;
        if (pos[i] == 1) return 1;
        if (pos[i] < 2 + ecyc[i]) return 2;
        return 3;
    endfunction

    function automatic int act_cnt(input int i);
        case (i)
            0:       return int'(c0);
            1:       return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit e);
        for (int i = 0; i < N; i++) begin
            if (!r) begin
                pos[i]  = 0;
                mcnt[i] = 0;
            end else if (e) begin
                if (pos[i] == ilen(i) - 1) begin
                    pos[i]  = 0;
                    mcnt[i] = (mcnt[i] + 1) % (1 << cw[i]);
                end else begin
                    pos[i]++;
                end
            end
        end
        if (!r) model_valid = 1'b1;
    endtask

    task automatic check_all();
        int ph;
        int exp_stb;
        int act_stb;
        bit act_en;
        if (!model_valid) return;
        act_en = reset && en;
        for (int i = 0; i < N; i++) begin
            ph      = exp_phase(i);
            exp_stb = act_en ? (8 >> ph) : 0;
            act_stb = {28'd0, fs[i], ds[i], es[i], ws[i]};
            check("state", i, int'(st[i]), ph);
            check("strobes", i, act_stb, exp_stb);
            check("instr_done", i, int'(dn[i]), int'(act_en && pos[i] == ilen(i) - 1));
            check("instr_count", i, act_cnt(i), mcnt[i]);
        end
        if (es[1]) exec_seen++;
        if (dn[1]) done_seen++;
    endtask

    // ------------------------------------------------------------ driver tasks
    task automatic apply(input bit r, input bit e);
        @(negedge clk);
        reset = r;
        en    = e;
        #1;
        check_all();
    endtask

    task automatic edge_done();
        @(posedge clk);
        model_edge(reset, en);
    endtask

    task automatic step(input bit r, input bit e);
        apply(r, e);
        edge_done();
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        bit       rst;
        bit       en;
        bit       done;   // instr_done of inst0 before the edge
        logic [1:0] st;   // inst0 state after the edge
        int       cnt;    // inst0 instr_count after the edge
    } vec_t;

    vec_t tbl[$];

    initial begin
`ifdef FDE_WRITEBACK_EN
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b11, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1});
`else
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'b00, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 2'b00, 2});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b01, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'b01, 2});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 2'b10, 2});
`endif

        // Reset-then-run and freeze, compared against the fixed table.
        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].en);
            check("tbl_done", 0, int'(dn[0]), int'(tbl[k].done));
            edge_done();
            #1;
            check("tbl_state", 0, int'(st[0]), int'(tbl[k].st));
            check("tbl_count", 0, int'(c0), tbl[k].cnt);
        end

        // Multi-cycle execute with en dropped for two cycles mid-EXECUTE.
        step(1'b0, 1'b1);
        exec_seen = 0;
        done_seen = 0;
        begin
            bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            foreach (pat[k]) step(1'b1, pat[k]);
        end
        if (WB != 0) step(1'b1, 1'b1);
        #1;
        check("pause_exec_cycles", 1, exec_seen, 3);
        check("pause_done_pulses", 1, done_seen, 1);
        check("pause_count", 1, int'(c1), 1);

        // Counter wrap on the 4-bit instance: 15 instructions, then the 16th.
        step(1'b0, 1'b1);
        for (int k = 0; k < 15 * ilen(1); k++) step(1'b1, 1'b1);
        #1;
        check("wrap_all_ones", 1, int'(c1), 15);
        for (int k = 0; k < ilen(1); k++) step(1'b1, 1'b1);
        #1;
        check("wrap_zero", 1, int'(c1), 0);

        // Reset mid-EXECUTE with instr_count=5 on inst1, en low during reset.
        step(1'b0, 1'b1);
        for (int k = 0; k < 200; k++) begin
            if (mcnt[1] == 5 && exp_phase(1) == 2) break;
            step(1'b1, 1'b1);
        end
        #1;
        check("pre_reset_state", 1, int'(st[1]), 2);
        check("pre_reset_count", 1, int'(c1), 5);
        step(1'b0, 1'b0);
        #1;
        check("mid_reset_state", 1, int'(st[1]), 0);
        check("mid_reset_count", 1, int'(c1), 0);

        // Randomized run against the model.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 70));
        end
        apply(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
